// File: rtl/mario_sprite_pkg.sv
// Shared types and constants for the Mario sprite sequencer and ROM address generator.
// The MARIO_SPRITE_MIRROR_EN build option is consumed by mario_anim_fsm and mario_sprite_ctrl.
package mario_sprite_pkg;

    typedef enum logic [2:0] {
        STAND = 3'd0,
        WALK1 = 3'd1,
        WALK2 = 3'd2,
        WALK3 = 3'd3,
        JUMP  = 3'd4
    } anim_state_t;

    localparam logic [3:0] SEL_STAND    = 4'd0;
    localparam logic [3:0] SEL_WALK1    = 4'd1;
    localparam logic [3:0] SEL_WALK2    = 4'd2;
    localparam logic [3:0] SEL_WALK3    = 4'd3;
    localparam logic [3:0] SEL_JUMP     = 4'd4;
    localparam logic [3:0] SEL_LEFT_OFS = 4'd5;

    localparam int          SPRITE_W_DEF  = 21;
    localparam int          SPRITE_H_DEF  = 21;
    localparam logic [23:0] KEY_COLOR_DEF = 24'h800080;

    function automatic logic [3:0] sel_base(input anim_state_t s);
        logic [3:0] sel;
        case (s)
            WALK1:   sel = SEL_WALK1;
            WALK2:   sel = SEL_WALK2;
            WALK3:   sel = SEL_WALK3;
            JUMP:    sel = SEL_JUMP;
            default: sel = SEL_STAND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mario_anim_fsm.sv
// Per-frame animation sequencer: state, facing, walk step counter and the registered ROM select.
// With MARIO_SPRITE_MIRROR_EN defined the select stays in 0..4; otherwise left facing adds 5.
module mario_anim_fsm
    import mario_sprite_pkg::*;
#(
    parameter int STEP_TICKS = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        airborne,
    output anim_state_t state_o,
    output logic        facing_left_o,
    output logic [3:0]  rom_sel_o
);

    localparam int                CNT_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_TICKS - 1);

    anim_state_t      state_q, state_d;
    logic             facing_left_q, facing_left_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rom_sel_q, rom_sel_d;
    logic             one_dir;

    assign one_dir = move_left ^ move_right;

    always_comb begin
        state_d       = state_q;
        facing_left_d = facing_left_q;
        cnt_d         = cnt_q;
        if (frame_tick) begin
            if (airborne) begin
                state_d = JUMP;
                cnt_d   = '0;
            end else if (one_dir) begin
                facing_left_d = move_left;
                // Entering a walk, or reversing mid-walk, restarts the cycle at WALK1.
                if (state_q == STAND || state_q == JUMP || move_left != facing_left_q) begin
                    state_d = WALK1;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    case (state_q)
                        WALK1:   state_d = WALK2;
                        WALK2:   state_d = WALK3;
                        default: state_d = WALK1;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                state_d = STAND;
                cnt_d   = '0;
            end
        end
        // Select is built from next-state so it lands on the same edge as the FSM update.
        rom_sel_d = sel_base(state_d);
`ifndef MARIO_SPRITE_MIRROR_EN
        if (facing_left_d) begin
            rom_sel_d = rom_sel_d + SEL_LEFT_OFS;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= STAND;
            facing_left_q <= 1'b0;
            cnt_q         <= '0;
            rom_sel_q     <= SEL_STAND;
        end else begin
            state_q       <= state_d;
            facing_left_q <= facing_left_d;
            cnt_q         <= cnt_d;
            rom_sel_q     <= rom_sel_d;
        end
    end

    assign state_o       = state_q;
    assign facing_left_o = facing_left_q;
    assign rom_sel_o     = rom_sel_q;

endmodule

// File: rtl/mario_sprite_ctrl.sv
// Mario sprite controller: animation select plus a 2-stage raster-to-ROM-address and chroma-key pipeline.
// Define MARIO_SPRITE_MIRROR_EN to mirror left-facing sprites from the right-facing ROMs.
module mario_sprite_ctrl
    import mario_sprite_pkg::*;
#(
    parameter int          SPRITE_W   = SPRITE_W_DEF,
    parameter int          SPRITE_H   = SPRITE_H_DEF,
    parameter int          ADDR_W     = 9,
    parameter int          STEP_TICKS = 6,
    parameter logic [23:0] KEY_COLOR  = KEY_COLOR_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_tick,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              airborne,
    input  logic [9:0]        mario_x,
    input  logic [9:0]        mario_y,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    output logic [3:0]        rom_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_color,
    output logic [23:0]       pix_color,
    output logic              pix_opaque
);

    localparam logic [10:0] SW = 11'(SPRITE_W);
    localparam logic [10:0] SH = 11'(SPRITE_H);

    anim_state_t anim_state;
    logic        facing_left;

    mario_anim_fsm #(
        .STEP_TICKS (STEP_TICKS)
    ) u_anim_fsm (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_tick    (frame_tick),
        .move_left     (move_left),
        .move_right    (move_right),
        .airborne      (airborne),
        .state_o       (anim_state),
        .facing_left_o (facing_left),
        .rom_sel_o     (rom_sel)
    );

    logic [10:0]       dx, dy, mx, my, col, row, col_eff, addr_full;
    logic              in_box_d, in_box_q;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic [23:0]       pix_color_d, pix_color_q;
    logic              pix_opaque_d, pix_opaque_q;

    // Stage 1: hit test in 11 bits so a sprite near the right/bottom edge never wraps.
    always_comb begin
        dx       = {1'b0, draw_x};
        dy       = {1'b0, draw_y};
        mx       = {1'b0, mario_x};
        my       = {1'b0, mario_y};
        in_box_d = (dx >= mx) && (dx < mx + SW) && (dy >= my) && (dy < my + SH);
        col      = dx - mx;
        row      = dy - my;
`ifdef MARIO_SPRITE_MIRROR_EN
        col_eff  = facing_left ? (SW - 11'd1 - col) : col;
`else
        col_eff  = col;
`endif
        addr_full  = row * SW + col_eff;
        rom_addr_d = in_box_d ? ADDR_W'(addr_full) : '0;
    end

    // Stage 2: rom_color answers rom_sel/rom_addr_q combinationally.
    always_comb begin
        pix_opaque_d = in_box_q && (rom_color != KEY_COLOR);
        pix_color_d  = pix_opaque_d ? rom_color : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q   <= '0;
            in_box_q     <= 1'b0;
            pix_color_q  <= '0;
            pix_opaque_q <= 1'b0;
        end else begin
            rom_addr_q   <= rom_addr_d;
            in_box_q     <= in_box_d;
            pix_color_q  <= pix_color_d;
            pix_opaque_q <= pix_opaque_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pix_color  = pix_color_q;
    assign pix_opaque = pix_opaque_q;

    // Select must always agree with the exposed animation state and facing.
    logic [3:0] sel_expect;
    always_comb begin
        sel_expect = sel_base(anim_state);
`ifndef MARIO_SPRITE_MIRROR_EN
        if (facing_left) begin
            sel_expect = sel_expect + SEL_LEFT_OFS;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset_n) begin
            assert (rom_sel == sel_expect);
        end
    end

endmodule

// File: doc/mario_sprite_ctrl.md
# mario_sprite_ctrl

Animation sequencer and sprite-ROM address generator for the Mario sprite. Each VGA frame it picks the animation frame (stand, three walk frames, jump) and facing from the movement inputs. Per pixel it converts the raster position into a 21x21 sprite-ROM read address and returns the ROM colour with chroma-key transparency. It sits between the player-physics block and the colour mapper, and drives the select of the sprite-ROM mux.

## Interface
Parameters:
- SPRITE_W, 21, sprite width in pixels
- SPRITE_H, 21, sprite height in pixels
- ADDR_W, 9, ROM address width (SPRITE_W*SPRITE_H ≤ 2^ADDR_W)
- STEP_TICKS, 6, frame_ticks per walk-frame advance (≥1)
- KEY_COLOR, 24'h800080, transparent palette colour

Ports:
- Clk  in  1  pixel/system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per VGA frame, asserted in vblank
- move_left, move_right  in  1 each  held movement requests from physics
- airborne  in  1  Mario not on ground
- mario_x, mario_y  in  10 each  sprite top-left, screen pixels
- draw_x, draw_y  in  10 each  current raster position
- rom_sel  out  4  sprite-ROM mux select
- rom_addr  out  ADDR_W  registered ROM read address
- rom_color  in  24  combinational ROM output for rom_sel/rom_addr
- pix_color  out  24  registered sprite colour
- pix_opaque  out  1  pix_color is a visible sprite pixel

## Operation
- Animation FSM states: STAND, WALK1, WALK2, WALK3, JUMP. The FSM, facing and step counter update only on cycles with frame_tick=1.
- Priority on each tick:
  - airborne → JUMP.
  - Else exactly one of move_left or move_right set:
    - from STAND or JUMP → WALK1, step counter = 0;
    - from a WALK state: counter+1; when it reaches STEP_TICKS-1, advance WALK1→WALK2→WALK3→WALK1 and clear the counter.
  - Else (none or both set) → STAND, counter = 0.
- Facing updates on a tick when exactly one direction is set. A reversal while walking restarts at WALK1 with counter 0. Facing is held in JUMP and STAND.
- rom_sel base: STAND=0, WALK1=1, WALK2=2, WALK3=3, JUMP=4.
- Hit test uses 11-bit unsigned arithmetic so mario_x+SPRITE_W cannot wrap: in_box = draw_x≥mario_x ∧ draw_x<mario_x+SPRITE_W ∧ same for y. col = draw_x−mario_x, row = draw_y−mario_y.
- rom_addr = row*SPRITE_W + col' (max 440). col' is defined under Configuration. rom_addr = 0 when not in_box.
- pix_opaque = in_box (delayed) ∧ rom_color ≠ KEY_COLOR. pix_color = rom_color when opaque, else 0.

## Timing
- Two-stage pipeline: draw_x/y sampled at edge N. rom_addr and the in_box flag are registered at N+1. pix_color/pix_opaque are registered at N+2. Latency is 2 cycles with throughput 1 pixel/cycle.
- rom_sel is registered and changes only the cycle after frame_tick, so it is stable across the visible frame.
- Reset values: FSM STAND, facing right, counter 0, rom_sel 0, rom_addr 0, pix_color 0, pix_opaque 0, pipeline valid flags 0.
- Reset asserted mid-frame clears everything asynchronously. The first valid pix_* appears 2 cycles after release.
- frame_tick on the same cycle as a pixel: the pixel in flight uses the old rom_sel and the next pixel uses the new one. A one-pixel seam during vblank is acceptable.

## Configuration
- MARIO_SPRITE_MIRROR_EN defined: only right-facing ROMs exist and rom_sel ∈ 0..4. Left facing uses col' = SPRITE_W−1−col.
- Undefined: col' = col. Left facing selects separate left ROMs via rom_sel = base+5 (5..9).

## Structure
- Package mario_sprite_pkg holds:
  - anim_state_t enum;
  - the rom_sel base constants;
  - SPRITE_W/SPRITE_H defaults;
  - KEY_COLOR.
- Sub-module mario_anim_fsm holds the FSM, facing and step counter. The top holds the address pipeline and the colour/transparency stage.

## Test plan
- Reset, then raster at draw=(100,50) with mario=(100,50) → rom_addr=0 at +1 and pix_opaque follows rom_color at +2. draw=(120,70) → rom_addr=440.
- move_right held, STEP_TICKS=6 → WALK1 for 6 ticks, then WALK2, WALK3, WALK1. rom_sel sequence 1,2,3,1.
- airborne with move_right → rom_sel=4 next tick. Clear airborne with no move → rom_sel=0.
- move_left held at draw=(100,50), mario=(100,50):
  - with MIRROR_EN: rom_addr=20, rom_sel=1;
  - without: rom_addr=0, rom_sel=6.
- rom_color=24'h800080 inside the box → pix_opaque=0, pix_color=0. draw_x=121, which is outside the box → rom_addr=0, pix_opaque=0.
- mario_x=1015 and draw_x=1023 → in_box=1 with no wrap. Assert Reset_n=0 mid-line → all outputs 0 immediately.
